// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for the flagged synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int MIN_ADDR_WIDTH     = 2;
  localparam int MAX_ADDR_WIDTH     = 12;

  function automatic bit fifo_params_legal(input int dw, input int aw, input int af, input int ae);
    int depth;
    if (dw < 1) return 1'b0;
    if ((aw < MIN_ADDR_WIDTH) || (aw > MAX_ADDR_WIDTH)) return 1'b0;
    depth = 1 << aw;
    if ((af < 1) || (af > depth - 1)) return 1'b0;
    if ((ae < 1) || (ae > depth - 1)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read, no reset on the array or read register.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/sync_fifo_flagged.sv
// Synchronous FIFO with registered occupancy flags and sticky overflow/underflow errors.
// Flags are computed from next-state pointers so they never lag the pointer update.
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  generate
    if (!fifo_params_legal(DATA_WIDTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("sync_fifo_flagged: illegal DATA_WIDTH/ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] AF_CNT  = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT  = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [ADDR_WIDTH:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic                r_full, r_empty, r_almost_full, r_almost_empty;
  logic                r_overflow, r_underflow, r_rd_valid, r_rd_seen;
  logic                w_wr_acc, w_rd_acc, w_full_nxt, w_empty_nxt;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    w_rd_ptr_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    w_full_nxt   = (w_wr_ptr_nxt[ADDR_WIDTH-1:0] == w_rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                   (w_wr_ptr_nxt[ADDR_WIDTH] != w_rd_ptr_nxt[ADDR_WIDTH]);
    w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_count_nxt  = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_seen      <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_full         <= w_full_nxt;
      r_empty        <= w_empty_nxt;
      r_almost_full  <= (w_count_nxt >= AF_CNT);
      r_almost_empty <= (w_count_nxt <= AE_CNT);
      // A new error in the same cycle as err_clr keeps the flag set.
      r_overflow     <= (wr_en && r_full)  ? 1'b1 : (err_clr ? 1'b0 : r_overflow);
      r_underflow    <= (rd_en && r_empty) ? 1'b1 : (err_clr ? 1'b0 : r_underflow);
      r_rd_valid     <= w_rd_acc;
      r_rd_seen      <= r_rd_seen | w_rd_acc;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk    (clk),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data(wr_data),
    .i_rd_en  (w_rd_acc),
    .i_rd_addr(r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data(w_ram_q)
  );

  // The RAM read register has no reset; mask it until a read has landed since reset.
  assign rd_data      = r_rd_seen ? w_ram_q : '0;
  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based FIFO model.
module tb_sync_fifo_flagged;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd_data;
  bit            exp_valid, exp_ovf, exp_udf;

  always #5 clk = ~clk;

  sync_fifo_flagged #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("rd_valid",     32'(rd_valid),     32'(exp_valid));
    chk("rd_data",      32'(rd_data),      32'(exp_rd_data));
    chk("overflow",     32'(overflow),     32'(exp_ovf));
    chk("underflow",    32'(underflow),    32'(exp_udf));
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_ovf   = (w && was_full)  ? 1'b1 : (c ? 1'b0 : exp_ovf);
    exp_udf   = (r && was_empty) ? 1'b1 : (c ? 1'b0 : exp_udf);
    exp_valid = r && !was_empty;
    if (exp_valid) exp_rd_data = q.pop_front();
    if (w && !was_full) q.push_back(d);
    check_all();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd_data = '0;
    exp_valid   = 1'b0;
    exp_ovf     = 1'b0;
    exp_udf     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, almost_full after 14th write, full after 16th.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 12) chk("af_before_14", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
    end
    chk("full_at_16", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("order_0_15", 32'(rd_data), 32'(i));
    end
    chk("empty_after_drain", 32'(empty), 32'd1);

    // Full with simultaneous write/read: read wins, write dropped, overflow set.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("ovf_full_rw_count", 32'(count), 32'd15);
    drain();

    // Error clear, then clear coinciding with a new overflow.
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i * 3), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);

    // Empty with simultaneous write/read: write wins, no bypass, underflow set.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("udf_empty_rw_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("udf_next_read", 32'(rd_data), 32'h55);
    step(1'b0, '0, 1'b0, 1'b1);

    // Steady concurrent traffic at count=8 across pointer wraps.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0);
    chk("steady_count", 32'(count), 32'd8);
    drain();

    // Random traffic in phases with varied write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(0, 99) < pw), DW'($urandom), ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < 5));
      end
    end
    drain();
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset at count=9 discards contents.
    for (int i = 0; i < 9; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h19, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_first", 32'(rd_data), 32'h3C);
    chk("post_reset_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
SYNC_FIFO_FLAGGED -- requirements
Module: sync_fifo_flagged

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..12.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold; legal range 1..DEPTH-1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_data  output  DATA_WIDTH  read word, registered.
REQ-011 rd_valid  output  1  rd_data valid this cycle.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 almost_full  output  1  occupancy >= AF_LEVEL.
REQ-015 almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-016 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky: write attempted while full.
REQ-018 underflow  output  1  sticky: read attempted while empty.
REQ-019 err_clr  input  1  synchronous clear of overflow/underflow.

Function
REQ-020 Pointers SHALL be ADDR_WIDTH+1 bits binary; extra MSB is the wrap bit; full when addresses equal and wrap bits differ, empty when pointers equal.
REQ-021 A write SHALL be accepted iff wr_en && !full; accepted word stored at wr_ptr, wr_ptr increments next edge.
REQ-022 A read SHALL be accepted iff rd_en && !empty; word at rd_ptr appears on rd_data with rd_valid=1 exactly one cycle later; rd_ptr increments.
REQ-023 rd_data SHALL hold its last value when no read is accepted; rd_valid SHALL be 0 that cycle.
REQ-024 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-025 When full with wr_en && rd_en: read accepted, write rejected, overflow set.
REQ-026 When empty with wr_en && rd_en: write accepted, read rejected, underflow set; no write-to-read bypass.
REQ-027 full, empty, almost_full, almost_empty and count SHALL be registered, updated on the same edge as the pointers, consistent with post-edge occupancy (no one-cycle lag).
REQ-028 Pointer wrap from 2*DEPTH-1 to 0 SHALL be seamless; flags correct across wrap.
REQ-029 overflow/underflow SHALL remain set until err_clr=1 or reset; if err_clr and a new error coincide, flag SHALL be 1 (set wins).
REQ-030 Rejected requests SHALL not alter pointers, memory or count.

Reset
REQ-031 On rst_n=0, asynchronously: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-032 Reset asserted mid-operation SHALL discard all contents; memory array is not cleared.
REQ-033 First accepted operation SHALL be the first rising edge with rst_n=1.

Structure
REQ-034 Shared package sync_fifo_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the flag-threshold legality checks.
REQ-035 Storage SHALL be sub-module sync_fifo_ram (simple dual-port, synchronous write, registered read, no reset); control/flag logic lives in sync_fifo_flagged.
REQ-036 Illegal parameters SHALL be rejected at elaboration.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=14, AE_LEVEL=2)
REQ-037 Write 0x00..0x0F back-to-back -> almost_full rises after 14th write, full=1 and count=16 after 16th; read 16 -> data 0x00..0x0F in order, empty=1 after last.
REQ-038 Full, wr_en=rd_en=1 with wr_data=0xAA -> one word read, count=15, overflow=1, 0xAA never read out.
REQ-039 Empty, wr_en=rd_en=1 with 0x55 -> count=1, rd_valid=0, underflow=1; next read returns 0x55.
REQ-040 Steady concurrent read/write for 40 cycles from count=8 -> count stays 8, pointers wrap twice, data order preserved.
REQ-041 overflow=1, pulse err_clr -> overflow=0 next cycle; err_clr coincident with write while full -> overflow stays 1.
REQ-042 rst_n low for one cycle at count=9 -> outputs at REQ-031 values immediately; subsequent write of 0x3C read back as first word.
